// File: rtl/reg_bank.sv
// Multi-register bank with load/increment/decrement on one write port,
// two combinational read ports with optional write-to-read forwarding, and carry/zero flags.
module reg_bank #(
  parameter int               WIDTH     = 19,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               BYPASS    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               wr_op,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_a,
  output logic [WIDTH-1:0]         rd_data_b,
  output logic                     carry,
  output logic                     zero
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [1:0]    OP_HOLD = 2'b00;
  localparam logic [1:0]    OP_LOAD = 2'b01;
  localparam logic [1:0]    OP_INC  = 2'b10;
  localparam logic [1:0]    OP_DEC  = 2'b11;

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_carry;
  logic             r_zero;

  logic             w_wr_in_range;
  logic             w_modify;
  logic             w_fwd_ok;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_next;
  logic             w_next_carry;

  // Result of one write-port operation; the extra MSB is the wrap carry on
  // increment and the borrow on decrement (0 - 1 sets it), and is 0 on load.
  function automatic logic [WIDTH:0] f_step(input logic [1:0]       op,
                                            input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] ld);
    logic [WIDTH:0] res;
    case (op)
      OP_LOAD: res = {1'b0, ld};
      OP_INC:  res = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC:  res = {1'b0, cur} - {{WIDTH{1'b0}}, 1'b1};
      default: res = {1'b0, cur};
    endcase
    return res;
  endfunction

  // Out-of-range addresses (non-power-of-two DEPTH) select nothing and read 0.
  function automatic logic [WIDTH-1:0] f_sel(input logic [AW-1:0] addr,
                                             input logic [WIDTH-1:0] regs [DEPTH]);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == i[AW-1:0]) val = regs[i];
    end
    return val;
  endfunction

  always_comb begin
    w_cur                  = f_sel(wr_addr, r_regs);
    w_wr_in_range          = ({1'b0, wr_addr} < DEPTH_C);
    w_modify               = w_wr_in_range && (wr_op != OP_HOLD);
    {w_next_carry, w_next} = f_step(wr_op, w_cur, wr_data);
    // Forwarding is suppressed during reset so reads reflect the reset contents next cycle.
    w_fwd_ok               = BYPASS && rst_n && w_modify;
  end

  always_comb begin
    rd_data_a = f_sel(rd_addr_a, r_regs);
    rd_data_b = f_sel(rd_addr_b, r_regs);
    if (w_fwd_ok && (rd_addr_a == wr_addr)) rd_data_a = w_next;
    if (w_fwd_ok && (rd_addr_b == wr_addr)) rd_data_b = w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= RESET_VAL;
      r_carry <= 1'b0;
      r_zero  <= (RESET_VAL == '0);
    end else if (w_modify) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == i[AW-1:0]) r_regs[i] <= w_next;
      end
      r_carry <= w_next_carry;
      r_zero  <= (w_next == '0);
    end
  end

  assign carry = r_carry;
  assign zero  = r_zero;

endmodule

// File: tb/tb_reg_bank.sv
// Directed-vector bench for reg_bank: default build, a no-forwarding build,
// and a DEPTH=6 build with nonzero reset value sharing one stimulus.
module tb_reg_bank;
  localparam int W = 19;
  localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, INC = 2'b10, DEC = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   wr_op;
  logic [2:0]   wr_addr, ra, rb;
  logic [W-1:0] wr_data;
  logic [W-1:0] a0, b0, a1, b1, a2, b2;
  logic         c0, z0, c1, z1, c2, z2;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(W), .DEPTH(8), .RESET_VAL(19'h00000), .BYPASS(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(a0), .rd_data_b(b0), .carry(c0), .zero(z0));

  reg_bank #(.WIDTH(W), .DEPTH(8), .RESET_VAL(19'h00000), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(a1), .rd_data_b(b1), .carry(c1), .zero(z1));

  reg_bank #(.WIDTH(W), .DEPTH(6), .RESET_VAL(19'h00010), .BYPASS(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(a2), .rd_data_b(b2), .carry(c2), .zero(z2));

  typedef struct {
    logic         rst_n;
    logic [1:0]   op;
    logic [2:0]   wa;
    logic [W-1:0] wd;
    logic [2:0]   ra;
    logic [2:0]   rb;
    bit           chk;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ec;
    logic         ez;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic r, logic [1:0] op, logic [2:0] wa, logic [W-1:0] wd,
                              logic [2:0] ra_i, logic [2:0] rb_i, bit chk,
                              logic [W-1:0] ea, logic [W-1:0] eb, logic ec, logic ez);
    vec_t v;
    v.rst_n = r;  v.op = op;    v.wa = wa;  v.wd = wd;  v.ra = ra_i; v.rb = rb_i;
    v.chk = chk;  v.ea = ea;    v.eb = eb;  v.ec = ec;  v.ez = ez;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] op, input logic [2:0] wa,
                       input logic [W-1:0] wd, input logic [2:0] ra_i, input logic [2:0] rb_i);
    @(negedge clk);
    rst_n = r; wr_op = op; wr_addr = wa; wr_data = wd; ra = ra_i; rb = rb_i;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_op = HOLD; wr_addr = '0; wr_data = '0; ra = '0; rb = '0;

    //           rst op    wa wd        ra rb chk ea        eb        c  z
    tv.push_back(mk(0, HOLD, 0, 19'h0,     0, 0, 0, 19'h0,     19'h0,     0, 1));
    tv.push_back(mk(0, HOLD, 0, 19'h0,     0, 7, 1, 19'h0,     19'h0,     0, 1));
    tv.push_back(mk(1, HOLD, 0, 19'h0,     3, 5, 1, 19'h0,     19'h0,     0, 1));
    tv.push_back(mk(1, LOAD, 3, 19'h000FE, 3, 2, 1, 19'h000FE, 19'h0,     0, 0));
    tv.push_back(mk(1, HOLD, 3, 19'h00FE6, 3, 3, 1, 19'h000FE, 19'h000FE, 0, 0));
    tv.push_back(mk(1, HOLD, 3, 19'h00FE6, 3, 3, 1, 19'h000FE, 19'h000FE, 0, 0));
    tv.push_back(mk(1, HOLD, 3, 19'h00FE6, 3, 3, 1, 19'h000FE, 19'h000FE, 0, 0));
    tv.push_back(mk(1, LOAD, 5, 19'h7FFFF, 5, 3, 1, 19'h7FFFF, 19'h000FE, 0, 0));
    tv.push_back(mk(1, INC,  5, 19'h0,     5, 5, 1, 19'h0,     19'h0,     1, 1));
    tv.push_back(mk(1, HOLD, 5, 19'h0,     5, 0, 1, 19'h0,     19'h0,     1, 1));
    tv.push_back(mk(1, INC,  5, 19'h0,     5, 1, 1, 19'h00001, 19'h0,     0, 0));
    tv.push_back(mk(1, DEC,  2, 19'h0,     2, 3, 1, 19'h7FFFF, 19'h000FE, 1, 0));
    tv.push_back(mk(1, HOLD, 0, 19'h0,     2, 5, 1, 19'h7FFFF, 19'h00001, 1, 0));
    tv.push_back(mk(1, DEC,  5, 19'h0,     4, 5, 1, 19'h0,     19'h0,     0, 1));
    tv.push_back(mk(1, INC,  2, 19'h0,     2, 2, 1, 19'h0,     19'h0,     1, 1));
    tv.push_back(mk(1, LOAD, 1, 19'h12345, 1, 1, 1, 19'h12345, 19'h12345, 0, 0));
    tv.push_back(mk(0, LOAD, 4, 19'h0ABCD, 4, 1, 1, 19'h0,     19'h12345, 0, 1));
    tv.push_back(mk(1, HOLD, 0, 19'h0,     4, 1, 1, 19'h0,     19'h0,     0, 1));
    tv.push_back(mk(1, INC,  0, 19'h0,     0, 7, 1, 19'h00001, 19'h0,     0, 0));
    tv.push_back(mk(1, LOAD, 7, 19'h0,     7, 0, 1, 19'h0,     19'h00001, 0, 1));
    tv.push_back(mk(1, DEC,  7, 19'h0,     7, 7, 1, 19'h7FFFF, 19'h7FFFF, 1, 0));
    tv.push_back(mk(1, LOAD, 6, 19'h3FFFF, 7, 6, 1, 19'h7FFFF, 19'h3FFFF, 0, 0));

    foreach (tv[i]) begin
      drive(tv[i].rst_n, tv[i].op, tv[i].wa, tv[i].wd, tv[i].ra, tv[i].rb);
      if (tv[i].chk) begin
        chk($sformatf("v%0d rd_a", i), 32'(a0), 32'(tv[i].ea));
        chk($sformatf("v%0d rd_b", i), 32'(b0), 32'(tv[i].eb));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d carry", i), 32'(c0), 32'(tv[i].ec));
      chk($sformatf("v%0d zero", i),  32'(z0), 32'(tv[i].ez));
    end

    // No-forwarding build shows the old value until the edge commits the load.
    drive(0, HOLD, 0, 19'h0, 1, 1);
    @(posedge clk); #1;
    chk("nobyp reset carry", 32'(c1), 32'h0);
    chk("nobyp reset zero",  32'(z1), 32'h1);
    drive(1, LOAD, 1, 19'h12345, 1, 1);
    chk("byp pre-edge a",    32'(a0), 32'h12345);
    chk("byp pre-edge b",    32'(b0), 32'h12345);
    chk("nobyp pre-edge a",  32'(a1), 32'h0);
    chk("nobyp pre-edge b",  32'(b1), 32'h0);
    @(posedge clk); #1;
    drive(1, HOLD, 1, 19'h0, 1, 1);
    chk("nobyp post-edge a", 32'(a1), 32'h12345);
    chk("nobyp post-edge b", 32'(b1), 32'h12345);

    // DEPTH=6 build: nonzero reset value, out-of-range writes ignored, out-of-range reads 0.
    drive(0, HOLD, 0, 19'h0, 0, 7);
    @(posedge clk); #1;
    chk("d6 reset zero",   32'(z2), 32'h0);
    chk("d6 reset carry",  32'(c2), 32'h0);
    drive(1, DEC, 7, 19'h0, 7, 0);
    chk("d6 rd oor a",     32'(a2), 32'h0);
    chk("d6 rd r0",        32'(b2), 32'h00010);
    @(posedge clk); #1;
    chk("d6 oor dec carry", 32'(c2), 32'h0);
    chk("d6 oor dec zero",  32'(z2), 32'h0);
    chk("d8 dec r7 carry",  32'(c0), 32'h1);
    drive(1, LOAD, 6, 19'h0, 6, 5);
    chk("d6 oor no fwd",   32'(a2), 32'h0);
    chk("d6 rd r5",        32'(b2), 32'h00010);
    @(posedge clk); #1;
    chk("d6 oor load zero", 32'(z2), 32'h0);
    drive(1, HOLD, 0, 19'h0, 0, 5);
    chk("d6 r0 intact",    32'(a2), 32'h00010);
    chk("d6 r5 intact",    32'(b2), 32'h00010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 19, data width of every register and port.
REQ-002 SHALL provide parameter DEPTH, default 8, number of registers (2..64).
REQ-003 SHALL provide parameter RESET_VAL, default 0, value loaded into every register at reset.
REQ-004 SHALL provide parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-005 SHALL derive AW = clog2(DEPTH) internally.
REQ-006 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL provide port rst_n, input, 1, reset, synchronous and active-low.
REQ-008 SHALL provide port wr_op, input, 2, write-port operation code.
REQ-009 SHALL provide port wr_addr, input, AW, target register for wr_op.
REQ-010 SHALL provide port wr_data, input, WIDTH, operand for load.
REQ-011 SHALL provide port rd_addr_a, input, AW, read port A select.
REQ-012 SHALL provide port rd_addr_b, input, AW, read port B select.
REQ-013 SHALL provide port rd_data_a, output, WIDTH, read port A data.
REQ-014 SHALL provide port rd_data_b, output, WIDTH, read port B data.
REQ-015 SHALL provide port carry, output, 1, registered carry/borrow of the last modifying op.
REQ-016 SHALL provide port zero, output, 1, registered zero flag of the last modifying op.

Function
REQ-017 SHALL decode wr_op per cycle: 00 hold, 01 load wr_data, 10 increment the addressed register, 11 decrement it.
REQ-018 SHALL commit the result to the addressed register on the rising edge; single-cycle latency; one register modified per cycle.
REQ-019 SHALL compute increment/decrement modulo 2^WIDTH: all-ones+1 -> 0, 0-1 -> all-ones.
REQ-020 SHALL set carry on inc wrap (all-ones -> 0) or dec borrow (0 -> all-ones), clear it on any other inc/dec and on load, and hold it on hold.
REQ-021 SHALL set zero to 1 when the committed result is 0, else 0; hold it on hold.
REQ-022 SHALL leave all registers and both flags unchanged when wr_addr >= DEPTH (non-power-of-two DEPTH).
REQ-023 SHALL drive rd_data_a/b combinationally from the addressed register; out-of-range address reads 0.
REQ-024 SHALL, when BYPASS=1, with wr_op != 00 and rd_addr == wr_addr (in range), forward the value about to be committed onto that read port in the same cycle.
REQ-025 SHALL, when BYPASS=0, always return pre-edge register contents.
REQ-026 SHALL serve both read ports independently, including the same address on both.

Reset
REQ-027 SHALL, on a rising edge with rst_n=0, load every register with RESET_VAL, set carry=0, and set zero=1 if RESET_VAL==0 else 0.
REQ-028 SHALL give reset priority over any wr_op in the same cycle; the pending operation is discarded, not deferred.
REQ-029 SHALL produce read outputs from the reset contents on the cycle after reset (bypass suppressed while rst_n=0).

Verification (WIDTH=19, DEPTH=8, RESET_VAL=0, BYPASS=1 unless stated)
REQ-030 Reset: rst_n=0 for 2 cycles -> every address reads 0x00000, carry=0, zero=1.
REQ-031 Load/hold: load r3=0x000FE; then wr_op=00, wr_data=0x00FE6 for 3 cycles -> r3 reads 0x000FE throughout, zero=0.
REQ-032 Inc wrap: load r5=0x7FFFF, then inc r5 -> r5=0x00000, carry=1, zero=1; inc again -> 0x00001, carry=0, zero=0.
REQ-033 Dec borrow: dec r2 from reset -> r2=0x7FFFF, carry=1, zero=0; other registers unchanged.
REQ-034 Bypass: load r1=0x12345 with rd_addr_a=rd_addr_b=1 -> both ports show 0x12345 before the edge; with BYPASS=0, old value 0x00000 until after the edge.
REQ-035 Reset mid-op: rst_n=0 while load r4=0x0ABCD -> r4=0x00000 after the edge, carry=0, zero=1.
